// File: rtl/bcd_clock_core.sv
// BCD HH:MM:SS time-of-day core with 12/24 h format, load, per-field adjust and alarm bank.
// Define BCD_CLOCK_ALARM_EN to build the alarm registers and comparators.
module bcd_clock_core #(
   parameter int unsigned ALARM_CH  = 2,
   parameter int unsigned HOUR_MODE = 24,
   localparam int unsigned AIW = (ALARM_CH > 1) ? $clog2(ALARM_CH) : 1
) (
   input  logic                CP,
   input  logic                CR_N,
   input  logic                TICK,
   input  logic                CE,
   input  logic                PE,
   input  logic [7:0]          D_H,
   input  logic [7:0]          D_M,
   input  logic [7:0]          D_S,
   input  logic                D_PM,
   input  logic                ADJ_UP,
   input  logic                ADJ_DN,
   input  logic [1:0]          ADJ_SEL,
   input  logic                AL_WE,
   input  logic [AIW-1:0]      AL_IDX,
   input  logic [7:0]          AL_H,
   input  logic [7:0]          AL_M,
   input  logic                AL_PM,
   input  logic                AL_ON,
   output logic [7:0]          Q_H,
   output logic [7:0]          Q_M,
   output logic [7:0]          Q_S,
   output logic                PM,
   output logic                TC_S,
   output logic                TC_M,
   output logic                TC_H,
   output logic                LD_ERR,
   output logic [ALARM_CH-1:0] AL_HIT
);

   localparam bit          IS12  = (HOUR_MODE == 12);
   localparam logic [7:0]  H_MIN = IS12 ? 8'h01 : 8'h00;
   localparam logic [7:0]  H_MAX = IS12 ? 8'h12 : 8'h23;
   localparam logic [7:0]  H_RST = IS12 ? 8'h12 : 8'h00;
   localparam logic [7:0]  MS_MAX = 8'h59;

   function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] lo,
                                          input logic [7:0] hi);
      if (v == hi) return lo;
      if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
      return {v[7:4], v[3:0] + 4'd1};
   endfunction

   function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] lo,
                                          input logic [7:0] hi);
      if (v == lo) return hi;
      if (v[3:0] == 4'd0) return {v[7:4] - 4'd1, 4'd9};
      return {v[7:4], v[3:0] - 4'd1};
   endfunction

   // Byte compares against lo/hi are valid once both nibbles are known to be decimal.
   function automatic logic bcd_ok(input logic [7:0] v, input logic [7:0] lo,
                                   input logic [7:0] hi);
      return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (v >= lo) && (v <= hi);
   endfunction

   logic [7:0]          nxt_h_c, nxt_m_c, nxt_s_c;
   logic                nxt_pm_c;
   logic                tc_s_c, tc_m_c, tc_h_c, ld_err_c, count_c, adj_c;
   logic [ALARM_CH-1:0] hit_c;

   // Next-time computation with priority load > adjust > tick.
   always_comb begin
      nxt_h_c  = Q_H;
      nxt_m_c  = Q_M;
      nxt_s_c  = Q_S;
      nxt_pm_c = PM;
      tc_s_c   = 1'b0;
      tc_m_c   = 1'b0;
      tc_h_c   = 1'b0;
      ld_err_c = 1'b0;
      count_c  = 1'b0;
      adj_c    = (ADJ_UP ^ ADJ_DN) && (ADJ_SEL != 2'd3);
      if (PE) begin
         if (bcd_ok(D_H, H_MIN, H_MAX) && bcd_ok(D_M, 8'h00, MS_MAX) &&
             bcd_ok(D_S, 8'h00, MS_MAX)) begin
            nxt_h_c  = D_H;
            nxt_m_c  = D_M;
            nxt_s_c  = D_S;
            nxt_pm_c = IS12 ? D_PM : 1'b0;
         end else begin
            ld_err_c = 1'b1;
         end
      end else if (adj_c) begin
         case (ADJ_SEL)
            2'd0: nxt_s_c = ADJ_UP ? bcd_inc(Q_S, 8'h00, MS_MAX) : bcd_dec(Q_S, 8'h00, MS_MAX);
            2'd1: nxt_m_c = ADJ_UP ? bcd_inc(Q_M, 8'h00, MS_MAX) : bcd_dec(Q_M, 8'h00, MS_MAX);
            default: begin
               if (ADJ_UP) begin
                  nxt_h_c = bcd_inc(Q_H, H_MIN, H_MAX);
                  if (IS12 && (Q_H == 8'h11)) nxt_pm_c = ~PM;
               end else begin
                  nxt_h_c = bcd_dec(Q_H, H_MIN, H_MAX);
                  if (IS12 && (Q_H == 8'h12)) nxt_pm_c = ~PM;
               end
            end
         endcase
      end else if (TICK && CE) begin
         count_c = 1'b1;
         nxt_s_c = bcd_inc(Q_S, 8'h00, MS_MAX);
         if (Q_S == MS_MAX) begin
            tc_s_c  = 1'b1;
            nxt_m_c = bcd_inc(Q_M, 8'h00, MS_MAX);
            if (Q_M == MS_MAX) begin
               tc_m_c  = 1'b1;
               nxt_h_c = bcd_inc(Q_H, H_MIN, H_MAX);
               if (IS12) begin
                  if (Q_H == 8'h11) begin
                     tc_h_c   = 1'b1;
                     nxt_pm_c = ~PM;
                  end
               end else if (Q_H == 8'h23) begin
                  tc_h_c = 1'b1;
               end
            end
         end
      end
   end

`ifdef BCD_CLOCK_ALARM_EN
   logic [7:0] al_h_r  [ALARM_CH];
   logic [7:0] al_m_r  [ALARM_CH];
   logic       al_pm_r [ALARM_CH];
   logic       al_on_r [ALARM_CH];
   logic       al_ok_c;

   assign al_ok_c = bcd_ok(AL_H, H_MIN, H_MAX) && bcd_ok(AL_M, 8'h00, MS_MAX);

   // Compare against the pre-write registers so a same-cycle write sees the old alarm.
   always_comb begin
      hit_c = '0;
      for (int i = 0; i < ALARM_CH; i++)
         hit_c[i] = count_c && (nxt_s_c == 8'h00) && al_on_r[i] && (al_h_r[i] == nxt_h_c) &&
                    (al_m_r[i] == nxt_m_c) && (al_pm_r[i] == nxt_pm_c);
   end

   always_ff @(posedge CP or negedge CR_N) begin
      if (!CR_N) begin
         for (int i = 0; i < ALARM_CH; i++) begin
            al_h_r[i]  <= 8'h00;
            al_m_r[i]  <= 8'h00;
            al_pm_r[i] <= 1'b0;
            al_on_r[i] <= 1'b0;
         end
      end else if (AL_WE && al_ok_c) begin
         for (int i = 0; i < ALARM_CH; i++) begin
            if (AL_IDX == AIW'(i)) begin
               al_h_r[i]  <= AL_H;
               al_m_r[i]  <= AL_M;
               al_pm_r[i] <= IS12 ? AL_PM : 1'b0;
               al_on_r[i] <= AL_ON;
            end
         end
      end
   end
`else
   logic unused_al;
   assign unused_al = ^{AL_WE, AL_IDX, AL_H, AL_M, AL_PM, AL_ON, count_c};
   assign hit_c     = '0;
`endif

   always_ff @(posedge CP or negedge CR_N) begin
      if (!CR_N) begin
         Q_H    <= H_RST;
         Q_M    <= 8'h00;
         Q_S    <= 8'h00;
         PM     <= 1'b0;
         TC_S   <= 1'b0;
         TC_M   <= 1'b0;
         TC_H   <= 1'b0;
         LD_ERR <= 1'b0;
         AL_HIT <= '0;
      end else begin
         Q_H    <= nxt_h_c;
         Q_M    <= nxt_m_c;
         Q_S    <= nxt_s_c;
         PM     <= nxt_pm_c;
         TC_S   <= tc_s_c;
         TC_M   <= tc_m_c;
         TC_H   <= tc_h_c;
         LD_ERR <= ld_err_c;
         AL_HIT <= hit_c;
      end
   end

endmodule

// File: tb/tb_bcd_clock_core.sv
// Directed bench for bcd_clock_core: one 24 h and one 12 h instance driven by shared stimulus.
module tb_bcd_clock_core;

   logic       cp = 1'b0;
   logic       cr_n;
   logic       tick, ce, pe, d_pm, adj_up, adj_dn;
   logic [7:0] d_h, d_m, d_s;
   logic [1:0] adj_sel;
   logic       al_we, al_pm, al_on;
   logic [0:0] al_idx;
   logic [7:0] al_h, al_m;

   logic [7:0] q_h24, q_m24, q_s24, q_h12, q_m12, q_s12;
   logic       pm24, pm12;
   logic       tc_s24, tc_m24, tc_h24, tc_s12, tc_m12, tc_h12;
   logic       ld_err24, ld_err12;
   logic [1:0] hit24, hit12;

   int checks   = 0;
   int failures = 0;

`ifdef BCD_CLOCK_ALARM_EN
   localparam logic [1:0] HIT_CH1 = 2'b10;
`else
   localparam logic [1:0] HIT_CH1 = 2'b00;
`endif

   always #5 cp = ~cp;

   bcd_clock_core #(.ALARM_CH(2), .HOUR_MODE(24)) u_dut24 (
      .CP(cp), .CR_N(cr_n), .TICK(tick), .CE(ce), .PE(pe),
      .D_H(d_h), .D_M(d_m), .D_S(d_s), .D_PM(d_pm),
      .ADJ_UP(adj_up), .ADJ_DN(adj_dn), .ADJ_SEL(adj_sel),
      .AL_WE(al_we), .AL_IDX(al_idx), .AL_H(al_h), .AL_M(al_m), .AL_PM(al_pm), .AL_ON(al_on),
      .Q_H(q_h24), .Q_M(q_m24), .Q_S(q_s24), .PM(pm24),
      .TC_S(tc_s24), .TC_M(tc_m24), .TC_H(tc_h24), .LD_ERR(ld_err24), .AL_HIT(hit24)
   );

   bcd_clock_core #(.ALARM_CH(2), .HOUR_MODE(12)) u_dut12 (
      .CP(cp), .CR_N(cr_n), .TICK(tick), .CE(ce), .PE(pe),
      .D_H(d_h), .D_M(d_m), .D_S(d_s), .D_PM(d_pm),
      .ADJ_UP(adj_up), .ADJ_DN(adj_dn), .ADJ_SEL(adj_sel),
      .AL_WE(al_we), .AL_IDX(al_idx), .AL_H(al_h), .AL_M(al_m), .AL_PM(al_pm), .AL_ON(al_on),
      .Q_H(q_h12), .Q_M(q_m12), .Q_S(q_s12), .PM(pm12),
      .TC_S(tc_s12), .TC_M(tc_m12), .TC_H(tc_h12), .LD_ERR(ld_err12), .AL_HIT(hit12)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] t24();
      return 32'({q_h24, q_m24, q_s24});
   endfunction

   function automatic logic [31:0] t12();
      return 32'({pm12, q_h12, q_m12, q_s12});
   endfunction

   function automatic logic [31:0] tc24();
      return 32'({tc_s24, tc_m24, tc_h24});
   endfunction

   function automatic logic [31:0] tc12();
      return 32'({tc_s12, tc_m12, tc_h12});
   endfunction

   task automatic cyc();
      @(posedge cp);
      #1;
   endtask

   task automatic do_load(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s,
                          input logic p);
      pe = 1'b1; d_h = h; d_m = m; d_s = s; d_pm = p;
      cyc();
      pe = 1'b0;
   endtask

   task automatic do_tick();
      tick = 1'b1;
      cyc();
      tick = 1'b0;
   endtask

   task automatic do_adj(input logic up, input logic dn, input logic [1:0] sel);
      adj_up = up; adj_dn = dn; adj_sel = sel;
      cyc();
      adj_up = 1'b0; adj_dn = 1'b0; adj_sel = 2'd3;
   endtask

   initial begin
      cr_n = 1'b0; tick = 1'b0; ce = 1'b1; pe = 1'b0; d_pm = 1'b0;
      d_h = 8'h00; d_m = 8'h00; d_s = 8'h00;
      adj_up = 1'b0; adj_dn = 1'b0; adj_sel = 2'd3;
      al_we = 1'b0; al_idx = 1'b0; al_h = 8'h00; al_m = 8'h00; al_pm = 1'b0; al_on = 1'b0;
      cyc(); cyc();
      check("rst_time24", t24(), 32'h000000);
      check("rst_time12", t12(), 32'h0120000);
      check("rst_pm24", 32'(pm24), 32'h0);
      check("rst_pulses", 32'({tc_s24, tc_m24, tc_h24, ld_err24, hit24, tc12(), ld_err12, hit12}), 32'h0);
      cr_n = 1'b1;
      cyc();

      // 24 h full rollover
      do_load(8'h23, 8'h59, 8'h58, 1'b0);
      check("load24", t24(), 32'h235958);
      check("load24_noerr", 32'(ld_err24), 32'h0);
      check("load12_bad_hour_err", 32'(ld_err12), 32'h1);
      check("load12_bad_hour_keep", t12(), 32'h0120000);
      do_tick();
      check("tick24_a", t24(), 32'h235959);
      check("tick24_a_tc", tc24(), 32'h0);
      do_tick();
      check("tick24_roll", t24(), 32'h000000);
      check("tick24_roll_tc", tc24(), 32'h7);
      cyc();
      check("tick24_tc_drop", tc24(), 32'h0);
      check("tick24_hold", t24(), 32'h000000);

      // 12 h: 11->12 toggles PM with TC_H, 12->01 does not
      do_load(8'h11, 8'h59, 8'h59, 1'b0);
      check("load12", t12(), 32'h0115959);
      do_tick();
      check("tick12_noon", t12(), 32'h1120000);
      check("tick12_noon_tc", tc12(), 32'h7);
      do_load(8'h12, 8'h59, 8'h59, 1'b1);
      check("load12_b", t12(), 32'h1125959);
      check("load24_pm_const", 32'(pm24), 32'h0);
      do_tick();
      check("tick12_one", t12(), 32'h1010000);
      check("tick12_one_tc", tc12(), 32'h6);
      check("tick24_13", t24(), 32'h130000);
      check("tick24_13_tc", tc24(), 32'h6);

      // Rejected loads
      do_load(8'h24, 8'h00, 8'h00, 1'b0);
      check("bad_hour_keep", t24(), 32'h130000);
      check("bad_hour_err", 32'(ld_err24), 32'h1);
      cyc();
      check("bad_hour_err_drop", 32'(ld_err24), 32'h0);
      do_load(8'h12, 8'h1A, 8'h00, 1'b0);
      check("bad_min_keep", t24(), 32'h130000);
      check("bad_min_err", 32'(ld_err24), 32'h1);
      check("bad_min_err12", 32'(ld_err12), 32'h1);
      cyc();
      check("bad_min_err_drop", 32'(ld_err24), 32'h0);

      // Field adjust without carry
      do_load(8'h10, 8'h59, 8'h30, 1'b0);
      do_adj(1'b1, 1'b0, 2'd1);
      check("adj_min_up", t24(), 32'h100030);
      check("adj_min_up_tc", tc24(), 32'h0);
      check("adj_min_up12", t12(), 32'h0100030);
      do_adj(1'b0, 1'b1, 2'd2);
      check("adj_hr_dn", t24(), 32'h090030);
      do_adj(1'b1, 1'b1, 2'd2);
      check("adj_both", t24(), 32'h090030);
      do_load(8'h01, 8'h00, 8'h00, 1'b0);
      do_adj(1'b0, 1'b1, 2'd0);
      check("adj_sec_wrap", t24(), 32'h010059);
      check("adj_sec_wrap_tc", tc24(), 32'h0);
      do_adj(1'b0, 1'b1, 2'd2);
      do_adj(1'b0, 1'b1, 2'd2);
      check("adj_hr24_wrap", t24(), 32'h230059);
      do_load(8'h12, 8'h00, 8'h00, 1'b1);
      do_adj(1'b0, 1'b1, 2'd2);
      check("adj12_12_to_11", t12(), 32'h0110000);
      do_adj(1'b1, 1'b0, 2'd2);
      check("adj12_11_to_12", t12(), 32'h1120000);
      do_adj(1'b1, 1'b0, 2'd2);
      check("adj12_12_to_01", t12(), 32'h1010000);
      do_adj(1'b0, 1'b1, 2'd2);
      check("adj12_01_to_12", t12(), 32'h1120000);
      check("adj12_tc", tc12(), 32'h0);

      // Alarm channel 1 at 07:30
      al_we = 1'b1; al_idx = 1'b1; al_h = 8'h07; al_m = 8'h30; al_pm = 1'b0; al_on = 1'b1;
      cyc();
      al_we = 1'b0;
      do_load(8'h07, 8'h29, 8'h59, 1'b0);
      check("alarm_preload_nohit", 32'(hit24), 32'h0);
      do_tick();
      check("alarm_hit24", 32'(hit24), 32'(HIT_CH1));
      check("alarm_hit12", 32'(hit12), 32'(HIT_CH1));
      check("alarm_time", t24(), 32'h073000);
      cyc();
      check("alarm_hit_drop", 32'(hit24), 32'h0);
      do_load(8'h07, 8'h30, 8'h00, 1'b0);
      check("alarm_load_nohit", 32'(hit24), 32'h0);

      // TICK dropped when coinciding with load
      tick = 1'b1;
      do_load(8'h05, 8'h06, 8'h07, 1'b0);
      tick = 1'b0;
      check("pe_tick_time", t24(), 32'h050607);
      check("pe_tick_tc", tc24(), 32'h0);
      ce = 1'b0;
      do_tick();
      check("ce_low_hold", t24(), 32'h050607);
      ce = 1'b1;
      do_tick();
      check("ce_high_count", t24(), 32'h050608);

      // Asynchronous reset mid-count
      tick = 1'b1;
      #2;
      cr_n = 1'b0;
      #1;
      check("async_rst24", t24(), 32'h000000);
      check("async_rst12", t12(), 32'h0120000);
      tick = 1'b0;
      cyc();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
